div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} after 32 iterations plus one sign-correction
// cycle. Divide-by-zero short-circuits to a zero result. The unit can be
// annulled by a pipeline flush while busy.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} divState_t;

    divState_t   state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        negQuot_q;
    logic        negRem_q;
    logic        ready_q;
    logic [63:0] result_q;

    logic        negA;
    logic        negB;
    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [64:0] shifted;
    logic [32:0] trialDiff;
    logic [64:0] work_d;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;

    // Operand magnitudes and one restoring step; 0x80000000 maps onto itself
    // and is read as unsigned 2^31, which keeps the overflow case exact.
    always_comb begin
        negA        = signed_div_i & opdata1_i[31];
        negB        = signed_div_i & opdata2_i[31];
        dividendMag = negA ? (~opdata1_i + 32'd1) : opdata1_i;
        divisorMag  = negB ? (~opdata2_i + 32'd1) : opdata2_i;
        shifted     = work_q << 1;
        trialDiff   = shifted[64:32] - {1'b0, divisor_q};
        work_d      = trialDiff[32] ? shifted : {trialDiff, shifted[31:1], 1'b1};
        quotFinal   = negQuot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        remFinal    = negRem_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
    end

    // Control FSM and datapath registers; outputs are registered here so
    // result/ready only change on a clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            case (state_q)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (start_i && !annul_i) begin
                        work_q    <= {33'd0, dividendMag};
                        divisor_q <= divisorMag;
                        negQuot_q <= negA ^ negB;
                        negRem_q  <= negA;
                        cnt_q     <= 6'd0;
                        state_q   <= (opdata2_i == 32'd0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        cnt_q   <= 6'd0;
                        state_q <= FREE;
                    end else if (cnt_q == 6'd0) begin
                        cnt_q <= 6'd1;
                    end else begin
                        cnt_q    <= 6'd0;
                        ready_q  <= 1'b1;
                        result_q <= 64'd0;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        cnt_q   <= 6'd0;
                        state_q <= FREE;
                    end else if (cnt_q != 6'd32) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 6'd1;
                    end else begin
                        cnt_q    <= 6'd0;
                        ready_q  <= 1'b1;
                        result_q <= {remFinal, quotFinal};
                        state_q  <= END;
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_q  <= 1'b0;
                        result_q <= 64'd0;
                        state_q  <= FREE;
                    end
                end
                default: begin
                    state_q <= FREE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule
